l15_tag_store_mw: RTL and testbench
===================================

Name: l15_tag_store_mw

Overview:
- Multi-way tag store for the L1.5 instruction cache.
- Successor to the single-port, single-way tag RAM wrapper. Generalised to NB_WAYS ways with a per-entry valid bit.
- Adds a registered tag compare (hit and hit-way outputs) and a built-in invalidate sweep FSM. The sweep runs automatically after reset and on request.
- Sits between the L1.5 cache controller and the tag storage; data RAMs are unaffected.

Parameters:
NB_WAYS, 4, number of ways (≥1)
TAG_WIDTH, 8, tag bits per entry (the stored entry is TAG_WIDTH+1 bits, including valid)
ADDR_WIDTH, 5, set index width; depth = 2**ADDR_WIDTH sets

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_i  in  1  access request, accepted when req_i & ready_o
we_i  in  1  1 = write, 0 = read/compare
way_we_i  in  NB_WAYS  per-way write enable (writes only)
addr_i  in  ADDR_WIDTH  set index
wdata_i  in  TAG_WIDTH  tag to write
valid_i  in  1  valid bit to write
cmp_tag_i  in  TAG_WIDTH  tag to compare on reads
flush_req_i  in  1  invalidate all entries
ready_o  out  1  store accepts requests
flush_busy_o  out  1  sweep in progress
resp_valid_o  out  1  read response valid
rdata_o  out  NB_WAYS*TAG_WIDTH  per-way stored tags, way 0 in the LSBs
rvalid_o  out  NB_WAYS  per-way valid bits
hit_o  out  1  at least one valid way matches
hit_way_o  out  NB_WAYS  matching ways
multi_hit_o  out  1  more than one way matches (error indication)

Behaviour:
- Storage: NB_WAYS banks of 2**ADDR_WIDTH x (TAG_WIDTH+1). Storage is not reset; the sweep is the only initialisation.
- FSM states:
  - SWEEP: set counter cnt; each cycle, all ways at set cnt are written with valid=0, tag=0. cnt increments. When cnt == 2**ADDR_WIDTH-1 is written, go to IDLE and clear cnt.
  - IDLE: accept accesses. flush_req_i=1 → SWEEP next cycle.
- Reset (asserted at any time, including mid-sweep):
  - state=SWEEP, cnt=0, so the sweep restarts from set 0.
  - Output reset values: ready_o=0, flush_busy_o=1, resp_valid_o=0, rdata_o=0, rvalid_o=0, hit_o=0, hit_way_o=0, multi_hit_o=0.
- ready_o = (state==IDLE); flush_busy_o = (state==SWEEP). Both are registered-state decodes with no combinational path from inputs.
- Sweep length: exactly 2**ADDR_WIDTH cycles.
- flush_req_i during SWEEP is ignored; the sweep already clears everything.
- Write (req_i & ready_o & we_i):
  - Ways with way_we_i[w]=1 store {valid_i, wdata_i} at addr_i.
  - No response. way_we_i=0 is a legal no-op.
- Read (req_i & ready_o & ~we_i):
  - cmp_tag_i and addr_i are captured in the access cycle.
  - Next cycle, resp_valid_o=1 and rdata_o/rvalid_o show the entry contents.
  - hit_way_o[w] = rvalid[w] & (rdata[w]==cmp_tag).
  - hit_o = |hit_way_o; multi_hit_o = popcount(hit_way_o) > 1.
  - Latency is 1 cycle; back-to-back reads give one response per cycle.
- Outputs hold their last values when resp_valid_o=0.
- Requests with ready_o=0 are dropped. The controller must hold or retry them.
- Simultaneous req_i (read or write) and flush_req_i in IDLE:
  - The access completes first. A read returns pre-flush contents the next cycle.
  - SWEEP starts the next cycle.
- Write then read of the same set in consecutive cycles: the read returns the new value.

Decomposition:
- Package l15_tag_pkg:
  - State enum (SWEEP, IDLE).
  - Default-parameter localparams.
  - Helper function to count ones, used for multi_hit.
- Sub-module l15_tag_bank: one way's storage.
  - Single-port, 1-cycle synchronous read, write enable.
  - Behavioural array, no reset; clk only.
  - Instantiated NB_WAYS times by generate.
- The top level holds the FSM, sweep counter, write muxing (sweep vs. access), compare pipeline and output registers.

Test Plan:
1. Reset then idle (defaults) → ready_o=0 and flush_busy_o=1 for exactly 32 cycles after rst falls, then ready_o=1. A read of set 31 returns rvalid_o=0000, hit_o=0.
2. Write set 5, way_we_i=0100, tag 0xA3, valid 1; then read set 5 with cmp_tag 0xA3 → next cycle resp_valid_o=1, hit_way_o=0100, hit_o=1, multi_hit_o=0. cmp_tag 0xA2 → hit_o=0.
3. Write tag 0x3C to ways 0 and 3 of set 12 (way_we_i=1001); read with cmp_tag 0x3C → hit_way_o=1001, multi_hit_o=1.
4. Populate sets 0..31 way 1; assert flush_req_i together with a read of set 7 → that read still hits; then ready_o=0 for 32 cycles; afterwards every set reads rvalid_o=0000.
5. Assert rst at sweep cycle 10 for 2 cycles → the sweep restarts at set 0 and ready_o returns exactly 32 cycles after rst deasserts. Requests during the sweep produce no response and no write.
6. Back-to-back reads of sets 1,2,3 → resp_valid_o high 3 consecutive cycles with matching rdata_o. A write to set 2 followed by a read of set 2 returns the written tag.

Source files
------------

// File: rtl/l15_tag_pkg.sv
// ----------------------------------------------------------------------------
// l15_tag_pkg
//   Shared types and helpers for the L1.5 instruction-cache multi-way tag
//   store: FSM state encoding, default geometry and a ones-counter used to
//   flag multi-way hits.
// ----------------------------------------------------------------------------
package l15_tag_pkg;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int unsigned DEF_NB_WAYS    = 4;
    localparam int unsigned DEF_TAG_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    // Population count over a hit vector (supports up to 32 ways).
    function automatic int unsigned count_ones(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/l15_tag_store_mw_bank.sv
// ----------------------------------------------------------------------------
// l15_tag_bank
//   Storage for one tag-store way: 2**AW entries of DW bits, single port,
//   synchronous write, 1-cycle synchronous read. The read register only
//   updates on a read enable so the last read value is held. No reset.
//
//   clk      in   clock
//   i_we     in   write enable
//   i_re     in   read enable
//   i_addr   in   entry index
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// ----------------------------------------------------------------------------
module l15_tag_bank #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/l15_tag_store_mw.sv
// ----------------------------------------------------------------------------
// l15_tag_store_mw
//   Multi-way tag store for the L1.5 instruction cache. NB_WAYS banks of
//   2**ADDR_WIDTH x {valid, tag}. An invalidate sweep clears every set after
//   reset and on flush_req_i; accesses are accepted only when idle. Reads
//   return the stored tags one cycle later together with a tag compare
//   against the captured cmp_tag_i.
//
//   clk           in   clock
//   rst           in   asynchronous reset, active-high
//   req_i         in   access request (taken when req_i & ready_o)
//   we_i          in   1 = write, 0 = read/compare
//   way_we_i      in   per-way write enable
//   addr_i        in   set index
//   wdata_i       in   tag to write
//   valid_i       in   valid bit to write
//   cmp_tag_i     in   tag to compare on reads
//   flush_req_i   in   invalidate all entries
//   ready_o       out  store accepts requests
//   flush_busy_o  out  sweep in progress
//   resp_valid_o  out  read response valid
//   rdata_o       out  per-way tags, way 0 in the LSBs
//   rvalid_o      out  per-way valid bits
//   hit_o         out  any valid way matches
//   hit_way_o     out  matching ways
//   multi_hit_o   out  more than one way matches
// ----------------------------------------------------------------------------
module l15_tag_store_mw
    import l15_tag_pkg::*;
#(
    parameter int unsigned NB_WAYS    = DEF_NB_WAYS,
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [NB_WAYS-1:0]           way_we_i,
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [TAG_WIDTH-1:0]         wdata_i,
    input  logic                         valid_i,
    input  logic [TAG_WIDTH-1:0]         cmp_tag_i,
    input  logic                         flush_req_i,
    output logic                         ready_o,
    output logic                         flush_busy_o,
    output logic                         resp_valid_o,
    output logic [NB_WAYS*TAG_WIDTH-1:0] rdata_o,
    output logic [NB_WAYS-1:0]           rvalid_o,
    output logic                         hit_o,
    output logic [NB_WAYS-1:0]           hit_way_o,
    output logic                         multi_hit_o
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic                    r_resp_valid;
    logic                    r_rd_seen;
    logic [TAG_WIDTH-1:0]    r_cmp_tag;

    logic                    w_sweep;
    logic                    w_wr;
    logic                    w_rd;
    logic [NB_WAYS-1:0]      w_bank_we;
    logic [ADDR_WIDTH-1:0]   w_bank_addr;
    logic [TAG_WIDTH:0]      w_bank_wdata;
    logic [TAG_WIDTH:0]      w_bank_rdata [NB_WAYS];
    logic [NB_WAYS-1:0]      w_hit_way;

    assign w_sweep = (r_state == ST_SWEEP);
    assign w_wr    = req_i & (r_state == ST_IDLE) & we_i;
    assign w_rd    = req_i & (r_state == ST_IDLE) & ~we_i;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_SWEEP: begin
                // flush_req_i is ignored here: the sweep already clears all.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                // An access in the same cycle is still accepted; sweep follows.
                if (flush_req_i) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            default: begin
                w_state_nxt = ST_SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- bank port muxing (sweep vs. access) ----------------
    always_comb begin
        w_bank_addr  = w_sweep ? r_cnt : addr_i;
        w_bank_wdata = w_sweep ? '0 : {valid_i, wdata_i};
        for (int unsigned w = 0; w < NB_WAYS; w++) begin
            w_bank_we[w] = w_sweep | (w_wr & way_we_i[w]);
        end
    end

    for (genvar g = 0; g < NB_WAYS; g++) begin : g_way
        l15_tag_bank #(
            .AW (ADDR_WIDTH),
            .DW (TAG_WIDTH + 1)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_bank_we[g]),
            .i_re    (w_rd),
            .i_addr  (w_bank_addr),
            .i_wdata (w_bank_wdata),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // ---------------- compare pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_rd_seen    <= 1'b0;
            r_cmp_tag    <= '0;
        end else begin
            r_resp_valid <= w_rd;
            if (w_rd) begin
                r_rd_seen <= 1'b1;
                r_cmp_tag <= cmp_tag_i;
            end
        end
    end

    // The banks are not reset; r_rd_seen forces the response outputs to zero
    // until the first read after reset. Bank read registers only move on a
    // read, so the outputs hold between responses.
    always_comb begin
        rdata_o   = '0;
        rvalid_o  = '0;
        w_hit_way = '0;
        for (int unsigned w = 0; w < NB_WAYS; w++) begin
            rdata_o[w*TAG_WIDTH +: TAG_WIDTH] =
                w_bank_rdata[w][TAG_WIDTH-1:0] & {TAG_WIDTH{r_rd_seen}};
            rvalid_o[w]  = w_bank_rdata[w][TAG_WIDTH] & r_rd_seen;
            w_hit_way[w] = rvalid_o[w] &
                (rdata_o[w*TAG_WIDTH +: TAG_WIDTH] == r_cmp_tag);
        end
    end

    assign ready_o      = (r_state == ST_IDLE);
    assign flush_busy_o = (r_state == ST_SWEEP);
    assign resp_valid_o = r_resp_valid;
    assign hit_way_o    = w_hit_way;
    assign hit_o        = |w_hit_way;
    assign multi_hit_o  = (count_ones(32'(w_hit_way)) > 1);

endmodule

// File: tb/tb_l15_tag_store_mw.sv
// ----------------------------------------------------------------------------
// tb_l15_tag_store_mw
//   Directed bench for l15_tag_store_mw with hand-computed expectations.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_l15_tag_store_mw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [3:0]  way_we_i;
    logic [4:0]  addr_i;
    logic [7:0]  wdata_i;
    logic        valid_i;
    logic [7:0]  cmp_tag_i;
    logic        flush_req_i;
    logic        ready_o;
    logic        flush_busy_o;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic [3:0]  rvalid_o;
    logic        hit_o;
    logic [3:0]  hit_way_o;
    logic        multi_hit_o;

    int n_checks = 0;
    int n_pass   = 0;

    l15_tag_store_mw #(
        .NB_WAYS    (4),
        .TAG_WIDTH  (8),
        .ADDR_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .way_we_i     (way_we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .valid_i      (valid_i),
        .cmp_tag_i    (cmp_tag_i),
        .flush_req_i  (flush_req_i),
        .ready_o      (ready_o),
        .flush_busy_o (flush_busy_o),
        .resp_valid_o (resp_valid_o),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .hit_o        (hit_o),
        .hit_way_o    (hit_way_o),
        .multi_hit_o  (multi_hit_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] ways,
                            input logic [7:0] tag, input logic v);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; way_we_i = ways;
        wdata_i = tag; valid_i = v;
        tick();
        req_i = 1'b0; we_i = 1'b0; way_we_i = '0;
    endtask

    // Issues a read; on return the response of that read is on the outputs.
    task automatic do_read(input logic [4:0] a, input logic [7:0] cmp);
        req_i = 1'b1; we_i = 1'b0; addr_i = a; cmp_tag_i = cmp;
        tick();
        req_i = 1'b0;
    endtask

    // Ticks until ready_o, bounded; returns the number of not-ready cycles.
    task automatic count_busy(output int n);
        n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad_resp;

        rst = 1'b1; req_i = 0; we_i = 0; way_we_i = '0; addr_i = '0;
        wdata_i = '0; valid_i = 0; cmp_tag_i = '0; flush_req_i = 0;

        // ---- 1: reset values, sweep length, empty read ----
        tick(); tick(); tick();
        check("rst_ready",    ready_o,      1'b0);
        check("rst_busy",     flush_busy_o, 1'b1);
        check("rst_resp",     resp_valid_o, 1'b0);
        check("rst_rdata",    rdata_o,      32'h0);
        check("rst_rvalid",   rvalid_o,     4'h0);
        check("rst_hits",     {hit_o, hit_way_o, multi_hit_o}, 6'h0);
        rst = 1'b0;
        count_busy(n);
        check("sweep_len_rst", n, 32);
        check("idle_busy",     flush_busy_o, 1'b0);

        do_read(5'd31, 8'h00);
        check("s31_resp",   resp_valid_o, 1'b1);
        check("s31_rvalid", rvalid_o,     4'h0);
        check("s31_hit",    hit_o,        1'b0);
        tick();
        check("s31_resp_drop", resp_valid_o, 1'b0);

        // ---- 2: single-way hit and miss ----
        do_write(5'd5, 4'b0100, 8'hA3, 1'b1);
        do_read(5'd5, 8'hA3);
        check("s5_resp",    resp_valid_o, 1'b1);
        check("s5_rdata",   rdata_o,      32'h00A3_0000);
        check("s5_rvalid",  rvalid_o,     4'b0100);
        check("s5_hitway",  hit_way_o,    4'b0100);
        check("s5_hit",     hit_o,        1'b1);
        check("s5_multi",   multi_hit_o,  1'b0);
        tick();
        check("s5_hold_rdata", rdata_o, 32'h00A3_0000);
        check("s5_hold_hit",   hit_o,   1'b1);
        do_read(5'd5, 8'hA2);
        check("s5_miss_hit",    hit_o,     1'b0);
        check("s5_miss_hitway", hit_way_o, 4'b0000);

        // ---- 3: multi-way hit ----
        do_write(5'd12, 4'b1001, 8'h3C, 1'b1);
        do_read(5'd12, 8'h3C);
        check("s12_rdata",  rdata_o,     32'h3C00_003C);
        check("s12_hitway", hit_way_o,   4'b1001);
        check("s12_hit",    hit_o,       1'b1);
        check("s12_multi",  multi_hit_o, 1'b1);

        // ---- 6: back-to-back reads, write-then-read ----
        do_write(5'd1, 4'b0001, 8'h11, 1'b1);
        do_write(5'd2, 4'b0001, 8'h22, 1'b1);
        do_write(5'd3, 4'b0001, 8'h33, 1'b1);
        req_i = 1'b1; we_i = 1'b0; addr_i = 5'd1; cmp_tag_i = 8'h11;
        tick();
        check("b2b1", {resp_valid_o, rdata_o}, {1'b1, 32'h0000_0011});
        addr_i = 5'd2; cmp_tag_i = 8'h22;
        tick();
        check("b2b2", {resp_valid_o, rdata_o}, {1'b1, 32'h0000_0022});
        addr_i = 5'd3; cmp_tag_i = 8'h33;
        tick();
        check("b2b3", {resp_valid_o, rdata_o, hit_o}, {1'b1, 32'h0000_0033, 1'b1});
        req_i = 1'b0;
        tick();
        check("b2b_end", resp_valid_o, 1'b0);
        do_write(5'd2, 4'b0010, 8'h5A, 1'b1);
        do_read(5'd2, 8'h5A);
        check("wr_rd_rdata",  rdata_o,   32'h0000_5A22);
        check("wr_rd_hitway", hit_way_o, 4'b0010);

        // ---- 4: populate, flush with simultaneous read ----
        for (int s = 0; s < 32; s++) begin
            do_write(5'(s), 4'b0010, 8'(8'h40 + s), 1'b1);
        end
        req_i = 1'b1; we_i = 1'b0; addr_i = 5'd7; cmp_tag_i = 8'h47;
        flush_req_i = 1'b1;
        tick();
        req_i = 1'b0; flush_req_i = 1'b0;
        check("flush_rd_resp",   resp_valid_o, 1'b1);
        check("flush_rd_rdata",  rdata_o,      32'h0000_4700);
        check("flush_rd_hitway", hit_way_o,    4'b0010);
        check("flush_busy",      flush_busy_o, 1'b1);
        count_busy(n);
        check("sweep_len_flush", n, 32);
        for (int s = 0; s < 32; s++) begin
            do_read(5'(s), 8'(8'h40 + s));
            check($sformatf("clr_s%0d", s), {rvalid_o, hit_o, rdata_o}, 37'h0);
        end

        // ---- 5: reset mid-sweep, requests during sweep ----
        do_write(5'd9, 4'b1000, 8'hF0, 1'b1);
        do_read(5'd9, 8'hF0);
        check("s9_hit", {hit_o, rdata_o}, {1'b1, 32'hF000_0000});
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rdata", rdata_o, 32'h0);
        check("mid_rst_hit",   hit_o,   1'b0);
        tick(); tick();
        rst = 1'b0;
        n = 0;
        bad_resp = 0;
        while (!ready_o && n < 100) begin
            req_i = 1'b0; flush_req_i = 1'b0;
            if (n == 20) begin
                req_i = 1'b1; we_i = 1'b1; addr_i = 5'd0; way_we_i = 4'b1111;
                wdata_i = 8'h99; valid_i = 1'b1;
            end else if (n == 21) begin
                req_i = 1'b1; we_i = 1'b0; addr_i = 5'd0; cmp_tag_i = 8'h99;
            end else if (n == 25) begin
                flush_req_i = 1'b1;
            end
            tick();
            if (resp_valid_o) bad_resp++;
            n++;
        end
        req_i = 1'b0; we_i = 1'b0; way_we_i = '0; flush_req_i = 1'b0;
        check("sweep_len_mid_rst", n, 32);
        check("sweep_no_resp",     bad_resp, 0);
        do_read(5'd0, 8'h99);
        check("sweep_no_write", {rvalid_o, hit_o}, 5'h0);
        do_read(5'd9, 8'hF0);
        check("s9_cleared", {rvalid_o, hit_o}, 5'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
